// File: rtl/term_cursor_ctrl.sv
// rtl/term_cursor_ctrl.sv - terminal control command executor
// Owns cursor and saved cursor; streams erase cells and scroll steps to the framebuffer.
module term_cursor_ctrl #(
  parameter int ROWS = 24,
  parameter int COLS = 80,
  parameter int RW   = 5,
  parameter int CW   = 7
) (
  input  logic          clk,
  input  logic          _rst,
  input  logic          cmd_valid,
  input  logic [3:0]    cmd_code,
  input  logic [6:0]    arg_n,
  input  logic [6:0]    arg_m,
  output logic          cmd_ready,
  output logic          cmd_drop,
  output logic [RW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic          fb_req,
  output logic [1:0]    fb_op,
  output logic [RW-1:0] fb_row,
  output logic [CW-1:0] fb_col,
  input  logic          fb_ack
);
  localparam int CNTW = RW + 1;
  localparam logic [3:0] C_CUF = 4'd1, C_CUB = 4'd2, C_CNL = 4'd3, C_CPL = 4'd4;
  localparam logic [3:0] C_CHA = 4'd5, C_CUP = 4'd6, C_ED = 4'd7, C_EL = 4'd8;
  localparam logic [3:0] C_SU = 4'd9, C_SD = 4'd10, C_SCP = 4'd11, C_RCP = 4'd12;
  localparam logic [3:0] C_CLEAR = 4'd13, C_DEL = 4'd14;
  localparam logic [15:0] ROWS_M1 = 16'(ROWS - 1);
  localparam logic [15:0] COLS_M1 = 16'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_SCROLL} state_t;
  state_t state, state_nx;

  logic [RW-1:0]   sav_row, end_row;
  logic [CW-1:0]   sav_col, end_col;
  logic [CNTW-1:0] cnt, scr_cnt;
  logic            clr;
  logic [6:0]      n1, m1;
  logic [15:0]     n16, m16, col_add, row_add;
  logic [CW-1:0]   cuf_col, cub_col, cha_col, cup_col;
  logic [RW-1:0]   cnl_row, cpl_row, cup_row;
  logic            erase_cmd, scroll_cmd, last_cell;

  // Wide intermediates so sums never wrap before clamping.
  always_comb begin
    n1      = (arg_n == 7'd0) ? 7'd1 : arg_n;
    m1      = (arg_m == 7'd0) ? 7'd1 : arg_m;
    n16     = 16'(n1);
    m16     = 16'(m1);
    col_add = 16'(cur_col) + n16;
    row_add = 16'(cur_row) + n16;
    cuf_col = (col_add > COLS_M1) ? LAST_COL : CW'(col_add);
    cub_col = (n16 >= 16'(cur_col)) ? '0 : CW'(16'(cur_col) - n16);
    cnl_row = (row_add > ROWS_M1) ? LAST_ROW : RW'(row_add);
    cpl_row = (n16 >= 16'(cur_row)) ? '0 : RW'(16'(cur_row) - n16);
    cha_col = ((n16 - 16'd1) > COLS_M1) ? LAST_COL : CW'(n16 - 16'd1);
    cup_row = ((n16 - 16'd1) > ROWS_M1) ? LAST_ROW : RW'(n16 - 16'd1);
    cup_col = ((m16 - 16'd1) > COLS_M1) ? LAST_COL : CW'(m16 - 16'd1);
    scr_cnt = (n16 > 16'(ROWS)) ? CNTW'(ROWS) : CNTW'(n1);
    erase_cmd  = (((cmd_code == C_ED) || (cmd_code == C_EL)) && (arg_n <= 7'd2)) ||
                 (cmd_code == C_CLEAR) || (cmd_code == C_DEL);
    scroll_cmd = (cmd_code == C_SU) || (cmd_code == C_SD);
    last_cell  = (fb_row == end_row) && (fb_col == end_col);
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = (state == S_IDLE);
    fb_req    = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (cmd_valid && erase_cmd)       state_nx = S_ERASE;
        else if (cmd_valid && scroll_cmd) state_nx = S_SCROLL;
      end
      S_ERASE:  if (fb_ack && last_cell)       state_nx = S_IDLE;
      S_SCROLL: if (fb_ack && (cnt == CNTW'(1))) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      cur_row <= '0; cur_col <= '0; sav_row <= '0; sav_col <= '0;
      fb_row  <= '0; fb_col  <= '0; end_row <= '0; end_col <= '0;
      fb_op   <= 2'd0; cnt <= '0; clr <= 1'b0; cmd_drop <= 1'b0;
    end else begin
      if (cmd_valid && (state != S_IDLE)) cmd_drop <= 1'b1;
      case (state)
        S_IDLE: if (cmd_valid) begin
          if (erase_cmd) begin
            fb_op <= 2'd0;
            clr   <= (cmd_code == C_CLEAR);
          end
          if (scroll_cmd) begin
            fb_op <= (cmd_code == C_SU) ? 2'd1 : 2'd2;
            cnt   <= scr_cnt;
          end
          case (cmd_code)
            C_CUF: cur_col <= cuf_col;
            C_CUB: cur_col <= cub_col;
            C_CNL: begin cur_row <= cnl_row; cur_col <= '0; end
            C_CPL: begin cur_row <= cpl_row; cur_col <= '0; end
            C_CHA: cur_col <= cha_col;
            C_CUP: begin cur_row <= cup_row; cur_col <= cup_col; end
            C_SCP: begin sav_row <= cur_row; sav_col <= cur_col; end
            C_RCP: begin cur_row <= sav_row; cur_col <= sav_col; end
            C_ED: case (arg_n)
              7'd0: begin fb_row <= cur_row; fb_col <= cur_col; end_row <= LAST_ROW; end_col <= LAST_COL; end
              7'd1: begin fb_row <= '0; fb_col <= '0; end_row <= cur_row; end_col <= cur_col; end
              7'd2: begin fb_row <= '0; fb_col <= '0; end_row <= LAST_ROW; end_col <= LAST_COL; end
              default: ;
            endcase
            C_EL: case (arg_n)
              7'd0: begin fb_row <= cur_row; fb_col <= cur_col; end_row <= cur_row; end_col <= LAST_COL; end
              7'd1: begin fb_row <= cur_row; fb_col <= '0; end_row <= cur_row; end_col <= cur_col; end
              7'd2: begin fb_row <= cur_row; fb_col <= '0; end_row <= cur_row; end_col <= LAST_COL; end
              default: ;
            endcase
            C_CLEAR: begin fb_row <= '0; fb_col <= '0; end_row <= LAST_ROW; end_col <= LAST_COL; end
            C_DEL:   begin fb_row <= cur_row; fb_col <= cur_col; end_row <= cur_row; end_col <= cur_col; end
            default: ;
          endcase
        end
        S_ERASE: if (fb_ack) begin
          if (last_cell) begin
            if (clr) begin cur_row <= '0; cur_col <= '0; end
          end else if (fb_col == LAST_COL) begin
            fb_col <= '0;
            fb_row <= fb_row + RW'(1);
          end else begin
            fb_col <= fb_col + CW'(1);
          end
        end
        S_SCROLL: if (fb_ack) cnt <= cnt - CNTW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: doc/term_cursor_ctrl.md
Name: term_cursor_ctrl

Overview:
- Executes decoded terminal control commands from the escape-sequence decoder: ANSI CSI cursor moves, erase, scroll, save/restore cursor, plus the "clear" and delete commands.
- Owns the cursor position and the saved-cursor register.
- Sequences multi-cell erase and scroll work into the framebuffer through a req/ack handshake.
- Sits between the command decoder and the character framebuffer.

Parameters:
- ROWS, 24, screen rows.
- COLS, 80, screen columns.
- RW, 5, row index width (must satisfy 2^RW >= ROWS).
- CW, 7, column index width (must satisfy 2^CW >= COLS).

Ports:
- clk  in  1  system clock, rising edge.
- _rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  one-cycle command strobe.
- cmd_code  in  4  0 NOP, 1 CUF, 2 CUB, 3 CNL, 4 CPL, 5 CHA, 6 CUP/HVP, 7 ED, 8 EL, 9 SU, 10 SD, 11 SCP, 12 RCP, 13 CLEAR, 14 DEL, 15 reserved (treated as NOP).
- arg_n  in  7  first numeric CSI argument (raw; 0 means absent).
- arg_m  in  7  second numeric argument (CUP/HVP column).
- cmd_ready  out  1  high when a command can be accepted.
- cmd_drop  out  1  sticky; set when cmd_valid arrives while cmd_ready=0.
- cur_row  out  RW  cursor row, 0-based.
- cur_col  out  CW  cursor column, 0-based.
- fb_req  out  1  framebuffer operation request.
- fb_op  out  2  0 write blank at (fb_row, fb_col), 1 scroll up one line, 2 scroll down one line.
- fb_row  out  RW  target row.
- fb_col  out  CW  target column.
- fb_ack  in  1  framebuffer accepts the current request this cycle.

Behaviour:
- Reset (async, _rst=0):
  - State IDLE; cursor, saved cursor, fb_row, fb_col, fb_op = 0.
  - fb_req=0, cmd_drop=0, cmd_ready=1.
  - Applies immediately, including mid-erase or mid-scroll; no further framebuffer requests are issued.
- Acceptance:
  - A command is accepted on a rising edge with cmd_valid=1 and state IDLE.
  - cmd_ready = (state==IDLE), combinational from state.
  - cmd_valid while busy: the command is discarded, cmd_drop is set (cleared only by reset), and state/cursor are unaffected.
- Argument defaulting: n' = (arg_n==0 ? 1 : arg_n); m' likewise. ED/EL use raw arg_n as the mode.
- Single-cycle commands (result visible the cycle after accept, cmd_ready stays 1):
  - CUF: col = min(col+n', COLS-1).
  - CUB: col = max(col-n', 0).
  - CNL: row = min(row+n', ROWS-1), col = 0.
  - CPL: row = max(row-n', 0), col = 0.
  - CHA: col = min(n'-1, COLS-1).
  - CUP: row = min(n'-1, ROWS-1), col = min(m'-1, COLS-1).
  - SCP: saved = cursor. RCP: cursor = saved.
  - NOP / reserved: no effect.
  - ED/EL with mode > 2: no-op.
- Arithmetic: all sums are computed one bit wider than the operand, so nothing wraps before clamping.
- ERASE state. Erase targets are row-major inclusive ranges, latched at accept:
  - ED0: cursor .. (ROWS-1, COLS-1).
  - ED1: (0,0) .. cursor.
  - ED2 and CLEAR: (0,0) .. (ROWS-1, COLS-1).
  - EL0: cursor .. (row, COLS-1).
  - EL1: (row,0) .. cursor.
  - EL2: (row,0) .. (row, COLS-1).
  - DEL: the cursor cell only.
  - In ERASE, fb_op=0 and fb_req=1, with fb_row/fb_col = current cell.
  - On an edge with fb_ack=1: if the cell is the last, go to IDLE and drop fb_req; otherwise advance the column, wrapping to column 0 of the next row after COLS-1, and keep fb_req high.
  - CLEAR also sets cursor = (0,0) on the exit edge. All other erases leave the cursor unchanged.
- SCROLL state (SU/SD):
  - count = min(n', ROWS); fb_op = 1 (SU) or 2 (SD); fb_req held high.
  - Each fb_ack decrements count; exit to IDLE when count reaches 0.
  - Cursor unchanged.
- Handshake rules:
  - fb_req, fb_op, fb_row and fb_col are stable while fb_req=1 and fb_ack=0.
  - fb_ack is ignored when fb_req=0.
  - Throughput is one cell per cycle when fb_ack is tied high.
- Latency:
  - Erase of K cells with fb_ack tied high: fb_req high for K cycles starting the cycle after accept; cmd_ready=1 the cycle after the last ack.
  - CLEAR at 24x80: 1920 cycles.

Test Plan:
- CUP n=5,m=10 -> row 4, col 9 the next cycle. Then CUF n=100 -> col 79. Then CUB n=0 -> col 78. Then CPL n=9 -> row 0, col 0.
- CUP to (3,78) i.e. n=3,m=78 (row 2, col 77); EL n=0 with fb_ack tied 1 -> exactly 3 requests, op 0, at (2,77), (2,78), (2,79); cmd_ready=0 for 3 cycles, then 1.
- SU n=3 with fb_ack asserted 2 cycles after each req -> 3 op=1 transactions, fb_req/fb_op stable while waiting, cursor unchanged. Also SU n=0 -> 1 transaction; SD n=100 -> 24 transactions.
- CLEAR, then CUF strobe during erase -> CUF ignored, cmd_drop=1 and stays 1. After 1920 acks, cursor=(0,0) and cmd_ready=1.
- CUP n=4,m=5 -> (3,4); SCP; CUP n=0 -> (0,0); RCP -> (3,4). ED n=7 -> no requests, cmd_ready stays 1.
- CLEAR, then _rst pulsed low after 100 acks -> fb_req=0 asynchronously, cursor 0, cmd_ready=1, cmd_drop=0. No requests after reset release until a new command is accepted.
